// File: rtl/inst_rom_loader_if.sv
// Fetch and program-load signal bundle for the instruction ROM.
// master = processor/board side, slave = ROM side.
interface inst_rom_loader_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  load_start;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_ready;
  logic                  loading;
  logic [ADDR_WIDTH-1:0] load_count;
  logic                  load_done;

  modport master (
    output address, load_start, load_valid, load_data,
    input  instruction, load_ready, loading, load_count, load_done
  );

  modport slave (
    input  address, load_start, load_valid, load_data,
    output instruction, load_ready, loading, load_count, load_done
  );
endinterface

// File: rtl/inst_rom_loader.sv
// Register-based instruction ROM with a default program image and a
// handshaked full-image reload port; fetch output is NOP while loading.
module inst_rom_loader #(
  parameter int unsigned ROM_SIZE   = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  inst_rom_loader_if.slave  rom_bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(ROM_SIZE - 1);
  localparam logic [ADDR_WIDTH:0]   ROM_LIMIT = (ADDR_WIDTH + 1)'(ROM_SIZE);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] mem_q [ROM_SIZE];
  logic                  wr_en;

  function automatic logic [DATA_WIDTH-1:0] default_word(input int unsigned idx);
    case (idx)
      0:       return DATA_WIDTH'(16'h1205);
      1:       return DATA_WIDTH'(16'hB201);
      2:       return DATA_WIDTH'(16'hC400);
      3:       return DATA_WIDTH'(16'h8100);
      4:       return DATA_WIDTH'(16'hF200);
      5:       return DATA_WIDTH'(16'h8400);
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
    end
  end

  // Reset reloads the default image, so a partial load never survives it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ROM_SIZE; i++) begin
        mem_q[i] <= default_word(i);
      end
    end else if (wr_en) begin
      mem_q[cnt_q] <= rom_bus.load_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rom_bus.load_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (rom_bus.load_valid) begin
          wr_en = 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    instr_d = '0;
    if (state_q == IDLE && {1'b0, rom_bus.address} < ROM_LIMIT) begin
      instr_d = mem_q[rom_bus.address];
    end
  end

  assign rom_bus.instruction = instr_q;
  assign rom_bus.load_ready  = (state_q == LOAD);
  assign rom_bus.loading     = (state_q != IDLE);
  assign rom_bus.load_done   = (state_q == DONE);
  assign rom_bus.load_count  = cnt_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: default image, out-of-range fetch,
// full loads, gapped loads, async reset mid-load and start/valid overlap.
module tb_inst_rom_loader;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  inst_rom_loader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus  ();
  inst_rom_loader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus2 ();

  inst_rom_loader #(.ROM_SIZE(16), .ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .rom_bus (bus.slave)
  );

  inst_rom_loader #(.ROM_SIZE(12), .ADDR_WIDTH(4), .DATA_WIDTH(16)) dut12 (
    .clk     (clk),
    .rst     (rst),
    .rom_bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total_cnt++; if (bus.instruction !== 16'h0000) $display("FAIL reset_instr: got %h want 0000", bus.instruction); else pass_cnt++;
    total_cnt++; if (bus.load_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.load_ready); else pass_cnt++;
    total_cnt++; if (bus.loading !== 1'b0) $display("FAIL reset_loading: got %b want 0", bus.loading); else pass_cnt++;
    total_cnt++; if (bus.load_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", bus.load_count); else pass_cnt++;
    total_cnt++; if (bus.load_done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.load_done); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_default_fetch();
    logic [15:0] img [6];
    img = '{16'h1205, 16'hB201, 16'hC400, 16'h8100, 16'hF200, 16'h8400};
    for (int i = 0; i < 6; i++) begin
      bus.address = 4'(i);
      step();
      total_cnt++;
      if (bus.instruction !== img[i]) $display("FAIL default_fetch[%0d]: got %h want %h", i, bus.instruction, img[i]);
      else pass_cnt++;
    end
    bus.address = 4'd9;
    step();
    total_cnt++; if (bus.instruction !== 16'h0000) $display("FAIL default_fetch[9]: got %h want 0000", bus.instruction); else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    bus2.address = 4'd13;
    step();
    total_cnt++; if (bus2.instruction !== 16'h0000) $display("FAIL oor_addr13: got %h want 0000", bus2.instruction); else pass_cnt++;
    bus2.address = 4'd2;
    step();
    total_cnt++; if (bus2.instruction !== 16'hC400) $display("FAIL rom12_addr2: got %h want C400", bus2.instruction); else pass_cnt++;
    bus2.address = 4'd12;
    step();
    total_cnt++; if (bus2.instruction !== 16'h0000) $display("FAIL oor_addr12: got %h want 0000", bus2.instruction); else pass_cnt++;
  endtask

  task automatic test_full_load();
    bus.address    = 4'd0;
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 16'hA000 + 16'(i);
      total_cnt++; if (bus.load_ready !== 1'b1) $display("FAIL full_ready[%0d]: got %b want 1", i, bus.load_ready); else pass_cnt++;
      total_cnt++; if (bus.loading !== 1'b1) $display("FAIL full_loading[%0d]: got %b want 1", i, bus.loading); else pass_cnt++;
      total_cnt++; if (bus.load_count !== 4'(i)) $display("FAIL full_count[%0d]: got %0d want %0d", i, bus.load_count, i); else pass_cnt++;
      total_cnt++; if (bus.load_done !== 1'b0) $display("FAIL full_early_done[%0d]: got %b want 0", i, bus.load_done); else pass_cnt++;
      step();
      total_cnt++; if (bus.instruction !== 16'h0000) $display("FAIL full_nop[%0d]: got %h want 0000", i, bus.instruction); else pass_cnt++;
    end
    bus.load_valid = 1'b1;
    bus.load_data  = 16'hBEEF;
    bus.load_start = 1'b1;
    total_cnt++; if (bus.load_done !== 1'b1) $display("FAIL full_done: got %b want 1", bus.load_done); else pass_cnt++;
    total_cnt++; if (bus.load_ready !== 1'b0) $display("FAIL done_ready: got %b want 0", bus.load_ready); else pass_cnt++;
    total_cnt++; if (bus.loading !== 1'b1) $display("FAIL done_loading: got %b want 1", bus.loading); else pass_cnt++;
    total_cnt++; if (bus.load_count !== 4'd0) $display("FAIL done_count: got %0d want 0", bus.load_count); else pass_cnt++;
    step();
    bus.load_valid = 1'b0;
    bus.load_start = 1'b0;
    total_cnt++; if (bus.load_done !== 1'b0) $display("FAIL done_pulse_len: got %b want 0", bus.load_done); else pass_cnt++;
    total_cnt++; if (bus.loading !== 1'b0) $display("FAIL after_done_loading: got %b want 0", bus.loading); else pass_cnt++;
    total_cnt++; if (bus.instruction !== 16'h0000) $display("FAIL done_nop: got %h want 0000", bus.instruction); else pass_cnt++;
    bus.address = 4'd7;
    step();
    total_cnt++; if (bus.instruction !== 16'hA007) $display("FAIL full_read7: got %h want A007", bus.instruction); else pass_cnt++;
    total_cnt++; if (bus.loading !== 1'b0) $display("FAIL done_start_ignored: got %b want 0", bus.loading); else pass_cnt++;
    bus.address = 4'd0;
    step();
    total_cnt++; if (bus.instruction !== 16'hA000) $display("FAIL full_read0: got %h want A000", bus.instruction); else pass_cnt++;
    bus.address = 4'd15;
    step();
    total_cnt++; if (bus.instruction !== 16'hA00F) $display("FAIL full_read15: got %h want A00F", bus.instruction); else pass_cnt++;
  endtask

  task automatic test_gapped_load();
    int acc;
    acc = 0;
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    for (int c = 0; c < 60 && acc < 16; c++) begin
      bus.load_valid = (c % 3 == 0);
      bus.load_data  = 16'hB000 + 16'(c);
      bus.load_start = (c == 10);
      total_cnt++; if (bus.load_count !== 4'(acc)) $display("FAIL gap_count[c%0d]: got %0d want %0d", c, bus.load_count, acc); else pass_cnt++;
      step();
      if (c % 3 == 0) acc++;
    end
    bus.load_valid = 1'b0;
    bus.load_start = 1'b0;
    total_cnt++; if (acc != 16) $display("FAIL gap_timeout: got %0d words want 16", acc); else pass_cnt++;
    total_cnt++; if (bus.load_done !== 1'b1) $display("FAIL gap_done: got %b want 1", bus.load_done); else pass_cnt++;
    step();
    for (int k = 0; k < 16; k++) begin
      bus.address = 4'(k);
      step();
      total_cnt++;
      if (bus.instruction !== 16'hB000 + 16'(3 * k)) $display("FAIL gap_read[%0d]: got %h want %h", k, bus.instruction, 16'hB000 + 16'(3 * k));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_load();
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 16'hC000 + 16'(i);
      step();
    end
    bus.load_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    total_cnt++; if (bus.loading !== 1'b0) $display("FAIL async_loading: got %b want 0", bus.loading); else pass_cnt++;
    total_cnt++; if (bus.load_ready !== 1'b0) $display("FAIL async_ready: got %b want 0", bus.load_ready); else pass_cnt++;
    total_cnt++; if (bus.load_count !== 4'd0) $display("FAIL async_count: got %0d want 0", bus.load_count); else pass_cnt++;
    total_cnt++; if (bus.instruction !== 16'h0000) $display("FAIL async_instr: got %h want 0000", bus.instruction); else pass_cnt++;
    #2 rst = 1'b0;
    bus.address = 4'd0;
    step();
    total_cnt++; if (bus.instruction !== 16'h1205) $display("FAIL rst_img0: got %h want 1205", bus.instruction); else pass_cnt++;
    bus.address = 4'd3;
    step();
    total_cnt++; if (bus.instruction !== 16'h8100) $display("FAIL rst_img3: got %h want 8100", bus.instruction); else pass_cnt++;
    bus.address = 4'd4;
    step();
    total_cnt++; if (bus.instruction !== 16'hF200) $display("FAIL rst_img4: got %h want F200", bus.instruction); else pass_cnt++;
  endtask

  task automatic test_start_with_valid();
    bus.address    = 4'd0;
    bus.load_start = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 16'hFFFF;
    step();
    bus.load_start = 1'b0;
    total_cnt++; if (bus.load_count !== 4'd0) $display("FAIL overlap_count: got %0d want 0", bus.load_count); else pass_cnt++;
    total_cnt++; if (bus.load_ready !== 1'b1) $display("FAIL overlap_ready: got %b want 1", bus.load_ready); else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      bus.load_data = 16'hD000 + 16'(i);
      step();
    end
    bus.load_valid = 1'b0;
    total_cnt++; if (bus.load_done !== 1'b1) $display("FAIL overlap_done: got %b want 1", bus.load_done); else pass_cnt++;
    step();
    bus.address = 4'd0;
    step();
    total_cnt++; if (bus.instruction !== 16'hD000) $display("FAIL overlap_read0: got %h want D000", bus.instruction); else pass_cnt++;
    bus.address = 4'd1;
    step();
    total_cnt++; if (bus.instruction !== 16'hD001) $display("FAIL overlap_read1: got %h want D001", bus.instruction); else pass_cnt++;
    bus.address = 4'd15;
    step();
    total_cnt++; if (bus.instruction !== 16'hD00F) $display("FAIL overlap_read15: got %h want D00F", bus.instruction); else pass_cnt++;
  endtask

  initial begin
    pass_cnt        = 0;
    total_cnt       = 0;
    rst             = 1'b1;
    bus.address     = '0;
    bus.load_start  = 1'b0;
    bus.load_valid  = 1'b0;
    bus.load_data   = '0;
    bus2.address    = '0;
    bus2.load_start = 1'b0;
    bus2.load_valid = 1'b0;
    bus2.load_data  = '0;
    #2;
    test_reset();
    test_default_fetch();
    test_out_of_range();
    test_full_load();
    test_gapped_load();
    test_reset_mid_load();
    test_start_with_valid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
Instruction memory that answers the processor's fetch interface. The processor drives an address and this block returns the instruction at that address.
- Holds ROM_SIZE words in registers.
- Powers up and resets to a fixed default program image.
- A handshaked load port lets board-side logic replace the whole program at run time without re-synthesis.
- Sits between the processor fetch port and the board-side program source.

Parameters:
ROM_SIZE, 16, number of instruction words (2..2^ADDR_WIDTH)
ADDR_WIDTH, 4, width of fetch address
DATA_WIDTH, 16, instruction width

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  asynchronous, active-high reset
address  input  ADDR_WIDTH  fetch address from processor
instruction  output  DATA_WIDTH  registered fetched instruction
load_start  input  1  request to begin a full program load
load_valid  input  1  load_data holds a valid word
load_data  input  DATA_WIDTH  program word to write
load_ready  output  1  block accepts a word this cycle
loading  output  1  load in progress; fetch output forced to NOP
load_count  output  ADDR_WIDTH  index of next word to be written
load_done  output  1  one-cycle pulse when the last word is written

Behaviour:
- Reset (async, rst=1): all of the following hold immediately.
  - Memory returns to the default image: 0:0x1205 (load r1,5), 1:0xB201 (subi r1,1), 2:0xC400 (br 4), 3:0x8100 (jmp 1), 4:0xF200 (out r1), 5:0x8400 (jmp 4), 6..ROM_SIZE-1: 0x0000.
  - instruction=0x0000, load_ready=0, loading=0, load_count=0, load_done=0, state=IDLE.
  - Reset mid-load discards the partial load; the default image is restored, not the partial one.
- Fetch read: registered, 1-cycle latency. Each posedge, instruction <= mem[address].
  - If address >= ROM_SIZE, instruction <= 0x0000 (NOP).
  - In LOAD or DONE, instruction <= 0x0000 regardless of address.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: load_ready=0, loading=0. If load_start=1: go to LOAD, load_count<=0.
  - LOAD: load_ready=1, loading=1. Each cycle with load_valid=1, write mem[load_count]<=load_data and increment load_count.
    - If load_valid=0, nothing changes; there is no timeout.
    - When the word at index ROM_SIZE-1 is accepted, go to DONE and set load_count<=0; no wrap write occurs.
    - load_start is ignored while in LOAD.
  - DONE: exactly one cycle. load_done=1, load_ready=0, loading=1. Then go to IDLE.
    - load_valid in DONE is ignored.
    - load_start in DONE is ignored; it must be re-asserted in IDLE.
- First fetch returning new program data: instruction updates on the first posedge after DONE, reading the newly written words.
- load_start and load_valid asserted together in IDLE: only the state transition happens; that load_valid is not a write.
- Only load writes modify memory. The fetch side has no write path.
- Widths: load_count counts 0..ROM_SIZE-1. It is held in ADDR_WIDTH bits with no overflow, because the transition to DONE precedes the wrap.

Test Plan:
1. Reset release, address=0..5 on successive cycles -> instruction one cycle later equals 0x1205, 0xB201, 0xC400, 0x8100, 0xF200, 0x8400; address=9 -> 0x0000.
2. ROM_SIZE=12, address=13 -> instruction=0x0000.
3. load_start pulse, then 16 words 0xA000+i with load_valid held high.
   - Required: load_ready=1 for 16 cycles, loading high throughout, instruction=0x0000 throughout.
   - load_done pulses exactly once, the cycle after word 15 is accepted.
   - Afterwards, address=7 returns 0xA007.
4. During a load, toggle load_valid 1,0,0,1,... -> load_count advances only on valid cycles and the memory holds exactly the valid-cycle words in order. Re-asserting load_start mid-load has no effect.
5. Assert rst asynchronously after 5 of 16 load words -> outputs reset without waiting for a clock edge. After release, address=0 returns 0x1205 and address=3 returns 0x8100 (default image, not the partial load).
6. load_start together with load_valid=1 and load_data=0xFFFF in IDLE -> mem[0] is unchanged by that cycle. The first word written is the next valid word, and load_count=0 at LOAD entry.
